// File: rtl/pad_drive_seq.sv
// Core-to-pad drive sequencer: break-before-make turnaround, minimum level hold, power-safe state.
// Optional PAD_DRIVE_PWRGOOD_SYNC_EN adds a 2-flop synchronizer on pwr_good.
module pad_drive_seq #(
  parameter int unsigned TURN_CYC = 2,
  parameter int unsigned MIN_HOLD = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_out,
  input  logic req_oe,
  input  logic pwr_good,
  output logic pad_out,
  output logic pad_oe_n,
  output logic busy
);

  typedef enum logic [1:0] {StIdle, StTurn, StHold, StSafe} state_e;

  localparam logic [CNT_W-1:0] TurnLoad = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] HoldLoad = (MIN_HOLD > 1) ? CNT_W'(MIN_HOLD - 2) : '0;
  localparam bit               UseHold  = (MIN_HOLD > 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pad_out_q, pad_out_d;
  logic             pad_oe_n_q, pad_oe_n_d;
  logic             lvl_q, lvl_d;
  logic             pwr_good_s;
  logic             accept;

`ifdef PAD_DRIVE_PWRGOOD_SYNC_EN
  logic [1:0] pg_sync_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pg_sync_q <= 2'b00;
    end else begin
      pg_sync_q <= {pg_sync_q[0], pwr_good};
    end
  end

  assign pwr_good_s = pg_sync_q[1];
`else
  assign pwr_good_s = pwr_good;
`endif

  assign req_ready = (state_q == StIdle) & pwr_good_s & ~wb_rst_i;
  assign accept    = req_valid & req_ready;
  assign busy      = (state_q != StIdle);
  assign pad_out   = pad_out_q;
  assign pad_oe_n  = pad_oe_n_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pad_out_d  = pad_out_q;
    pad_oe_n_d = pad_oe_n_q;
    lvl_d      = lvl_q;
    if (!pwr_good_s) begin
      // Power loss overrides everything; any pending request is dropped.
      state_d    = StSafe;
      cnt_d      = '0;
      pad_out_d  = 1'b0;
      pad_oe_n_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (!req_oe) begin
              pad_oe_n_d = 1'b1;
              pad_out_d  = 1'b0;
            end else if (!pad_oe_n_q) begin
              if (req_out != pad_out_q) begin
                pad_out_d = req_out;
                if (UseHold) begin
                  state_d = StHold;
                  cnt_d   = HoldLoad;
                end
              end
            end else begin
              // Not driving yet: keep oe_n high for the turnaround first.
              lvl_d   = req_out;
              state_d = StTurn;
              cnt_d   = TurnLoad;
            end
          end
        end
        StTurn: begin
          if (cnt_q == '0) begin
            pad_oe_n_d = 1'b0;
            pad_out_d  = lvl_q;
            if (UseHold) begin
              state_d = StHold;
              cnt_d   = HoldLoad;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StSafe: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pad_out_q  <= 1'b0;
      pad_oe_n_q <= 1'b1;
      lvl_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pad_out_q  <= pad_out_d;
      pad_oe_n_q <= pad_oe_n_d;
      lvl_q      <= lvl_d;
    end
  end

endmodule

// File: tb/tb_pad_drive_seq.sv
// Directed bench for pad_drive_seq (default build): expectations queued per step, popped and
// compared as {pad_oe_n, pad_out, req_ready, busy} one cycle later.
module tb_pad_drive_seq;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic req_out = 1'b0;
  logic req_oe = 1'b0;
  logic pwr_good = 1'b1;
  logic pad_out;
  logic pad_oe_n;
  logic busy;

  typedef struct {
    string      tag;
    logic [3:0] v;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  pad_drive_seq #(
    .TURN_CYC(2),
    .MIN_HOLD(4),
    .CNT_W   (4)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_out  (req_out),
    .req_oe   (req_oe),
    .pwr_good (pwr_good),
    .pad_out  (pad_out),
    .pad_oe_n (pad_oe_n),
    .busy     (busy)
  );

  task automatic compare_head();
    exp_t       e;
    logic [3:0] obs;
    if (q.size() == 0) begin
      errors++;
      checks++;
      $error("FAIL scoreboard_empty obs=none exp=entry");
      return;
    end
    e   = q.pop_front();
    obs = {pad_oe_n, pad_out, req_ready, busy};
    checks++;
    assert (obs === e.v)
    else begin
      errors++;
      $error("FAIL %s obs(oe_n,out,rdy,busy)=%b exp=%b", e.tag, obs, e.v);
    end
  endtask

  // Expect values after the next rising edge.
  task automatic edge_chk(input string tag, input logic [3:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
    @(posedge wb_clk_i);
    #1;
    compare_head();
  endtask

  // Expect values right now (combinational req_ready).
  task automatic now_chk(input string tag, input logic [3:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
    #1;
    compare_head();
  endtask

  task automatic req(input logic v, input logic oe, input logic o);
    req_valid = v;
    req_oe    = oe;
    req_out   = o;
  endtask

  initial begin
    // 1: reset
    edge_chk("rst0", 4'b1000);
    edge_chk("rst1", 4'b1000);
    edge_chk("rst2", 4'b1000);
    wb_rst_i = 1'b0;
    now_chk("rst_rel_ready", 4'b1010);
    edge_chk("idle_after_rst", 4'b1010);

    // 2: enable via turnaround, then held-valid level change after hold
    req(1'b1, 1'b1, 1'b1);
    edge_chk("turn_k", 4'b1001);
    req(1'b0, 1'b0, 1'b0);
    edge_chk("turn_k1", 4'b1001);
    edge_chk("drive_k2", 4'b0101);
    req(1'b1, 1'b1, 1'b0);
    edge_chk("hold_k3", 4'b0101);
    edge_chk("hold_k4", 4'b0101);
    edge_chk("idle_k5", 4'b0110);
    edge_chk("chg0_k6", 4'b0001);
    req(1'b0, 1'b0, 1'b0);
    edge_chk("hold0_a", 4'b0001);
    edge_chk("hold0_b", 4'b0001);
    edge_chk("idle0", 4'b0010);

    // 3: change back to 1, then same-level request is a no-op
    req(1'b1, 1'b1, 1'b1);
    edge_chk("chg1", 4'b0101);
    req(1'b0, 1'b0, 1'b0);
    edge_chk("hold1_a", 4'b0101);
    edge_chk("hold1_b", 4'b0101);
    edge_chk("idle1", 4'b0110);
    req(1'b1, 1'b1, 1'b1);
    edge_chk("same_level", 4'b0110);

    // 4: disable, then immediate re-enable goes through turnaround
    req(1'b1, 1'b0, 1'b1);
    edge_chk("disable", 4'b1010);
    req(1'b1, 1'b1, 1'b1);
    edge_chk("reen_turn_a", 4'b1001);
    req(1'b0, 1'b0, 1'b0);
    edge_chk("reen_turn_b", 4'b1001);
    edge_chk("reen_drive", 4'b0101);
    edge_chk("reen_hold_a", 4'b0101);
    edge_chk("reen_hold_b", 4'b0101);
    edge_chk("reen_idle", 4'b0110);

    // 5: power loss during turnaround; request must be discarded
    req(1'b1, 1'b0, 1'b0);
    edge_chk("dis2", 4'b1010);
    req(1'b1, 1'b1, 1'b1);
    edge_chk("pl_turn", 4'b1001);
    req(1'b0, 1'b0, 1'b0);
    pwr_good = 1'b0;
    edge_chk("safe_enter", 4'b1001);
    edge_chk("safe_stay", 4'b1001);
    pwr_good = 1'b1;
    edge_chk("safe_exit", 4'b1010);
    edge_chk("no_stale_drive", 4'b1010);
    req(1'b1, 1'b1, 1'b1);
    pwr_good = 1'b0;
    now_chk("ready_gated_pg", 4'b1000);
    edge_chk("safe_from_idle", 4'b1001);
    req(1'b0, 1'b0, 1'b0);
    pwr_good = 1'b1;
    edge_chk("safe_exit2", 4'b1010);

    // 6: reset during hold while driving 1
    req(1'b1, 1'b1, 1'b1);
    edge_chk("r6_turn_a", 4'b1001);
    req(1'b0, 1'b0, 1'b0);
    edge_chk("r6_turn_b", 4'b1001);
    edge_chk("r6_drive", 4'b0101);
    wb_rst_i = 1'b1;
    edge_chk("r6_reset", 4'b1000);
    wb_rst_i = 1'b0;
    now_chk("r6_release", 4'b1010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pad_drive_seq.md
Name: pad_drive_seq

Overview:
- Output-direction companion to the pad input conditioning path. The input path buffers and conditions the pad before the core samples it; this block is the core-to-pad drive side.
- Accepts drive requests (level plus output enable) from the core over a valid/ready handshake.
- Enforces break-before-make turnaround and a minimum hold time per driven level.
- Forces the pad into a safe, non-driving state whenever power-good is low.

Parameters:
- TURN_CYC, 2, cycles pad_oe_n stays high after an enable request before the pad drives (>=1).
- MIN_HOLD, 4, minimum cycles a driven level is held before the next change (>=1).
- CNT_W, 4, counter width; must hold max(TURN_CYC, MIN_HOLD).

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous active-high reset.
- req_valid  in  1  drive request valid.
- req_ready  out  1  block can accept a request this cycle.
- req_out  in  1  requested pad level.
- req_oe  in  1  requested output enable (1 = drive).
- pwr_good  in  1  pad supply good (1 = powered).
- pad_out  out  1  registered level to pad.
- pad_oe_n  out  1  registered active-low pad output enable.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (sampled wb_rst_i=1, highest priority):
  - state=IDLE, pad_out=0, pad_oe_n=1, counter=0.
  - req_ready=0 while wb_rst_i=1.
- req_ready = (state==IDLE) & pwr_good_s & !wb_rst_i. pwr_good_s is pwr_good, or its synchronized version when the optional feature is compiled in.
- Accept = req_valid & req_ready at a rising edge (edge k). A request is never dropped once accepted, except by reset or power loss.
- States: IDLE, TURN, HOLD, SAFE.
- IDLE accept, req_oe=1, currently driving (pad_oe_n=0):
  - req_out == pad_out: no change, stay IDLE, req_ready stays 1.
  - req_out != pad_out: pad_out<=req_out at k. If MIN_HOLD>1, go to HOLD with counter<=MIN_HOLD-2; otherwise stay IDLE.
- IDLE accept, req_oe=1, not driving:
  - Latch req_out, go to TURN, counter<=TURN_CYC-1. pad_oe_n stays 1.
- TURN:
  - At each edge, if counter==0: pad_oe_n<=0, pad_out<=latched level, then enter HOLD (counter<=MIN_HOLD-2) or IDLE if MIN_HOLD==1.
  - Otherwise decrement the counter.
  - Net effect: pad drives starting at edge k+TURN_CYC.
- HOLD:
  - At each edge, if counter==0 go to IDLE, else decrement.
  - Net effect: after a level change at edge D, the earliest next accept is edge D+MIN_HOLD, so every driven level persists >= MIN_HOLD cycles.
- IDLE accept, req_oe=0:
  - pad_oe_n<=1 and pad_out<=0 at k; stay IDLE.
  - A later enable always passes through TURN.
- Power loss (pwr_good_s=0 at any edge, any state, not in reset):
  - Next state SAFE; pad_oe_n<=1, pad_out<=0.
  - Any in-progress TURN/HOLD is abandoned; the latched request is discarded.
- SAFE:
  - Go to IDLE at the first edge where pwr_good_s=1. Pad remains disabled.
- Simultaneous accept and pwr_good_s falling cannot occur, since req_ready is gated by pwr_good_s.
- Reset mid-TURN/HOLD/SAFE: immediate return to reset values at that edge.

Optional Feature:
- Macro: PAD_DRIVE_PWRGOOD_SYNC_EN.
- Defined: pwr_good passes through a 2-flop synchronizer (reset value 0) to form pwr_good_s.
  - Entry to and exit from SAFE are delayed by 2 cycles.
  - req_ready rises no earlier than 2 cycles after reset release.
- Undefined: pwr_good_s = pwr_good directly; pwr_good is required to be synchronous to wb_clk_i.

Test Plan:
1. Reset: wb_rst_i=1 for 3 cycles, pwr_good=1 -> pad_oe_n=1, pad_out=0, req_ready=0, busy=0. After release, req_ready=1 in the next cycle (feature off).
2. Enable with TURN_CYC=2, MIN_HOLD=4: accept {oe=1,out=1} at edge k -> pad_oe_n=1 through edge k+1; pad_oe_n=0 and pad_out=1 after edge k+2; req_ready=0 until edge k+5. A second request {1,0}, held valid, is accepted at k+6 -> pad_out=0 after k+6.
3. While driving 1, request {1,1} -> accepted, no output change, busy stays 0, req_ready stays 1.
4. While driving, request {0,x} -> pad_oe_n=1 and pad_out=0 at the accept edge. An immediate {1,1} then keeps pad_oe_n=1 for 2 cycles before driving.
5. pwr_good=0 during TURN -> next edge SAFE, pad_oe_n=1, latched request lost. pwr_good=1 again -> IDLE after 1 edge, pad stays disabled, req_ready=1.
6. wb_rst_i=1 during HOLD with pad driving 1 -> pad_oe_n=1, pad_out=0, state IDLE at that edge. With PAD_DRIVE_PWRGOOD_SYNC_EN defined, repeat scenario 5 -> SAFE entry delayed by 2 cycles.
